// File: rtl/main_memory_ctrl_pkg.sv
// Shared definitions for the main memory controller: FSM state encoding,
// block/word/address geometry, address field positions and the reset-time
// contents of a block.
package main_memory_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BLOCK_BITS      = 128;
    localparam int WORD_BITS       = 32;
    localparam int ADDR_BITS       = 10;
    localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;

    localparam int IDX_MSB  = 9;
    localparam int IDX_LSB  = 4;
    localparam int OFS_MSB  = 3;
    localparam int OFS_LSB  = 2;
    localparam int IDX_BITS = IDX_MSB - IDX_LSB + 1;
    localparam int OFS_BITS = OFS_MSB - OFS_LSB + 1;

    localparam int CNT_BITS = 4;

    // Word w of the whole memory (w = byte address >> 2) resets to w.
    // Word 0 of a block occupies the most significant lane.
    function automatic logic [BLOCK_BITS-1:0] init_block(input logic [IDX_BITS-1:0] idx);
        logic [BLOCK_BITS-1:0] blk;
        blk = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            blk[BLOCK_BITS-1-i*WORD_BITS -: WORD_BITS] = WORD_BITS'({idx, OFS_BITS'(i)});
        end
        return blk;
    endfunction

endpackage

// File: rtl/main_memory_ctrl_mem_block_array.sv
// Block storage for the main memory controller.
//   clk, reset : system clock, synchronous active-high reset (loads init pattern)
//   we_i       : per-word write enable, bit w writes word w (word 0 = [127:96])
//   wr_idx_i   : block index written
//   wr_data_i  : write data, lane-aligned with the block layout
//   rd_idx_i   : block index read
//   rd_data_o  : combinational read data
module mem_block_array
    import main_memory_ctrl_pkg::*;
#(
    parameter int NUM_BLOCKS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORDS_PER_BLOCK-1:0] we_i,
    input  logic [IDX_BITS-1:0]        wr_idx_i,
    input  logic [BLOCK_BITS-1:0]      wr_data_i,
    input  logic [IDX_BITS-1:0]        rd_idx_i,
    output logic [BLOCK_BITS-1:0]      rd_data_o
);

    logic [BLOCK_BITS-1:0] mem_q [NUM_BLOCKS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                mem_q[b] <= init_block(IDX_BITS'(b));
            end
        end else begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                if (we_i[w]) begin
                    mem_q[wr_idx_i][BLOCK_BITS-1-w*WORD_BITS -: WORD_BITS] <=
                        wr_data_i[BLOCK_BITS-1-w*WORD_BITS -: WORD_BITS];
                end
            end
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/main_memory_ctrl.sv
// Main memory controller: accepts one block read, block write or word write
// from the cache, holds it for LATENCY busy cycles, then completes it with a
// single memReady pulse.
//   clk, reset    : system clock, synchronous active-high reset
//   memReq        : request strobe, only looked at while idle
//   isMemRead     : 1 = block read, 0 = write
//   isWordWrite   : write only; 1 = single word [31:0], 0 = whole block
//   memAddress    : byte address, [9:4] block, [3:2] word
//   memWriteData  : write data
//   memReadData   : last completed read block, word 0 in [127:96]
//   memReady      : one-cycle completion pulse
//   memBusy       : high from acceptance through the memReady cycle
//
// state | meaning
// IDLE  | waiting for memReq
// BUSY  | request latched, counting down the access latency
// DONE  | operation performed, memReady asserted for this one cycle
module main_memory_ctrl
    import main_memory_ctrl_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int NUM_BLOCKS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memReq,
    input  logic                  isMemRead,
    input  logic                  isWordWrite,
    input  logic [ADDR_BITS-1:0]  memAddress,
    input  logic [BLOCK_BITS-1:0] memWriteData,
    output logic [BLOCK_BITS-1:0] memReadData,
    output logic                  memReady,
    output logic                  memBusy
);

    state_e                    state_q, state_d;
    logic [CNT_BITS-1:0]       cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0]     rdata_q, rdata_d;
    logic                      rd_q, ww_q;
    logic [IDX_MSB:OFS_LSB]    addr_q;
    logic [BLOCK_BITS-1:0]     wdata_q;
    logic                      latch_en;
    logic                      do_op;
    logic [WORDS_PER_BLOCK-1:0] we;
    logic [BLOCK_BITS-1:0]     arr_wdata;
    logic [BLOCK_BITS-1:0]     arr_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            ww_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (latch_en) begin
                rd_q    <= isMemRead;
                ww_q    <= isWordWrite;
                addr_q  <= memAddress[IDX_MSB:OFS_LSB];
                wdata_q <= memWriteData;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        do_op    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memReq) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_BITS'(LATENCY - 1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    do_op   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A word write replicates the word into every lane and enables only the
    // addressed one, so the array needs no lane-steering of its own.
    always_comb begin
        we        = '0;
        arr_wdata = wdata_q;
        if (do_op && !rd_q) begin
            if (ww_q) begin
                we        = WORDS_PER_BLOCK'(1) << addr_q[OFS_MSB:OFS_LSB];
                arr_wdata = {WORDS_PER_BLOCK{wdata_q[WORD_BITS-1:0]}};
            end else begin
                we = '1;
            end
        end
    end

    assign rdata_d = (do_op && rd_q) ? arr_rdata : rdata_q;

    mem_block_array #(
        .NUM_BLOCKS(NUM_BLOCKS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .we_i      (we),
        .wr_idx_i  (addr_q[IDX_MSB:IDX_LSB]),
        .wr_data_i (arr_wdata),
        .rd_idx_i  (addr_q[IDX_MSB:IDX_LSB]),
        .rd_data_o (arr_rdata)
    );

    assign memReadData = rdata_q;
    assign memReady    = (state_q == ST_DONE);
    assign memBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_main_memory_ctrl.sv
module tb_main_memory_ctrl;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         memReq, req1, req15;
    logic         isMemRead, isWordWrite;
    logic [9:0]   memAddress;
    logic [127:0] memWriteData;
    logic [127:0] rdata, rdata1, rdata15;
    logic         ready, ready1, ready15;
    logic         busy, busy1, busy15;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    main_memory_ctrl #(.LATENCY(L)) dut (
        .clk(clk), .reset(reset), .memReq(memReq), .isMemRead(isMemRead),
        .isWordWrite(isWordWrite), .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(rdata), .memReady(ready), .memBusy(busy));

    main_memory_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .memReq(req1), .isMemRead(isMemRead),
        .isWordWrite(isWordWrite), .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(rdata1), .memReady(ready1), .memBusy(busy1));

    main_memory_ctrl #(.LATENCY(15)) dut15 (
        .clk(clk), .reset(reset), .memReq(req15), .isMemRead(isMemRead),
        .isWordWrite(isWordWrite), .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(rdata15), .memReady(ready15), .memBusy(busy15));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the L=4 instance ----------------
    // A request accepted at edge e completes at edge e+L (ready visible after
    // it); the next request can be accepted no earlier than edge e+L+2.
    logic [31:0]  mw [256];
    logic [127:0] m_rd;
    bit           m_ready, m_busy, model_valid = 0;
    int           e = 0, acc = 0;
    bit           acc_v = 0;
    bit           p_rd, p_ww;
    logic [9:0]   p_addr;
    logic [127:0] p_data;

    always @(posedge clk) begin
        int b;
        e++;
        if (reset) begin
            for (int w = 0; w < 256; w++) mw[w] = 32'(w);
            acc_v = 0; m_rd = '0; m_ready = 0; m_busy = 0; model_valid = 1;
        end else begin
            if (acc_v && e == acc + L) begin
                b = int'(p_addr[9:4]);
                if (p_rd)
                    m_rd = {mw[4*b], mw[4*b+1], mw[4*b+2], mw[4*b+3]};
                else if (p_ww)
                    mw[int'(p_addr[9:2])] = p_data[31:0];
                else
                    for (int i = 0; i < 4; i++) mw[4*b+i] = p_data[127-32*i -: 32];
            end
            if ((!acc_v || e >= acc + L + 2) && memReq) begin
                acc = e; acc_v = 1;
                p_rd = isMemRead; p_ww = isWordWrite; p_addr = memAddress; p_data = memWriteData;
            end
            m_busy  = acc_v && e >= acc && e <= acc + L;
            m_ready = acc_v && e == acc + L;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("ready", 128'(ready), 128'(m_ready));
            check("busy", 128'(busy), 128'(m_busy));
            check("rdata", rdata, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int which, input bit rd, input bit ww, input logic [9:0] addr,
                          input logic [127:0] data, input bit scramble,
                          output int lat, output logic [127:0] got);
        logic r;
        @(negedge clk);
        isMemRead = rd; isWordWrite = ww; memAddress = addr; memWriteData = data;
        case (which)
            1: req1 = 1'b1;
            2: req15 = 1'b1;
            default: memReq = 1'b1;
        endcase
        @(negedge clk);
        memReq = 1'b0; req1 = 1'b0; req15 = 1'b0;
        if (scramble) begin
            isMemRead = ~rd; isWordWrite = ~ww;
            memAddress = 10'($urandom);
            memWriteData = {$urandom, $urandom, $urandom, $urandom};
        end
        lat = 1;
        r = (which == 1) ? ready1 : (which == 2) ? ready15 : ready;
        while (!r && lat < 40) begin
            @(negedge clk);
            lat++;
            r = (which == 1) ? ready1 : (which == 2) ? ready15 : ready;
        end
        got = (which == 1) ? rdata1 : (which == 2) ? rdata15 : rdata;
    endtask

    initial begin
        int lat;
        int rp[$];
        int nready;
        logic [127:0] got;

        reset = 1'b1; memReq = 0; req1 = 0; req15 = 0;
        isMemRead = 0; isWordWrite = 0; memAddress = '0; memWriteData = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 128'(ready), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_rdata", rdata, 128'd0);
        reset = 1'b0;

        do_req(0, 1, 0, 10'h010, '0, 1, lat, got);
        check("read010_lat", 128'(lat), 128'd5);
        check("read010_data", got, {32'h4, 32'h5, 32'h6, 32'h7});

        do_req(0, 0, 0, 10'h3F0, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 1, lat, got);
        check("wr3F0_lat", 128'(lat), 128'd5);
        check("wr3F0_rdata_kept", got, {32'h4, 32'h5, 32'h6, 32'h7});
        do_req(0, 1, 0, 10'h3F0, '0, 0, lat, got);
        check("read3F0_data", got, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);

        do_req(0, 0, 1, 10'h028, {96'hFFFF_FFFF_1234_5678_9ABC_DEF0, 32'hDEADBEEF}, 1, lat, got);
        do_req(0, 1, 0, 10'h020, '0, 0, lat, got);
        check("read020_data", got, {32'h8, 32'h9, 32'hDEADBEEF, 32'hB});

        // memReq held high with the address toggling every cycle
        @(negedge clk);
        isMemRead = 1; isWordWrite = 0; memAddress = 10'h010; memReq = 1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            memAddress = (memAddress == 10'h010) ? 10'h3F0 : 10'h010;
            if (ready) rp.push_back(i);
        end
        memReq = 0;
        check("held_pulses", 128'(rp.size()), 128'd6);
        foreach (rp[k]) check("held_pulse_pos", 128'(rp[k]), 128'(4 + 6 * k));

        // reset during the second busy cycle of a block write
        @(negedge clk);
        isMemRead = 0; isWordWrite = 0; memAddress = 10'h100; memWriteData = '1; memReq = 1;
        @(negedge clk);
        memReq = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        nready = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready) nready++;
        end
        check("abort_no_ready", 128'(nready), 128'd0);
        do_req(0, 1, 0, 10'h100, '0, 0, lat, got);
        check("read100_init", got, {32'h40, 32'h41, 32'h42, 32'h43});

        do_req(1, 1, 0, 10'h010, '0, 1, lat, got);
        check("lat1_lat", 128'(lat), 128'd2);
        check("lat1_data", got, {32'h4, 32'h5, 32'h6, 32'h7});
        do_req(2, 1, 0, 10'h010, '0, 1, lat, got);
        check("lat15_lat", 128'(lat), 128'd16);
        check("lat15_data", got, {32'h4, 32'h5, 32'h6, 32'h7});

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 Parameter LATENCY, default 4, number of BUSY cycles between request acceptance and completion (legal 1..15).
REQ-002 Parameter NUM_BLOCKS, default 64, number of 128-bit blocks stored; byte address width is 10.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memReq  input  1  request strobe from cache; sampled only in IDLE.
REQ-006 isMemRead  input  1  1 = block read, 0 = write.
REQ-007 isWordWrite  input  1  for writes only: 1 = single-word write-through, 0 = full-block write-back.
REQ-008 memAddress  input  10  byte address; [9:4] block index, [3:2] word offset, [1:0] ignored.
REQ-009 memWriteData  input  128  block write data; word writes use [31:0] only.
REQ-010 memReadData  output  128  block read data; word 0 in [127:96], word 3 in [31:0].
REQ-011 memReady  output  1  one-cycle completion pulse for every accepted request.
REQ-012 memBusy  output  1  high from acceptance through the memReady cycle inclusive.

Function
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE with memReq=1: latch isMemRead, isWordWrite, memAddress, memWriteData; load counter with LATENCY-1; go BUSY.
REQ-015 BUSY: decrement counter each cycle; at counter 0 perform the latched operation on the array and go DONE.
REQ-016 DONE: memReady=1 for exactly one cycle; next state IDLE unconditionally.
REQ-017 Latency: request sampled at edge N gives memReady high in the cycle after edge N+LATENCY.
REQ-018 memReq while BUSY or DONE is ignored; no queueing; caller re-asserts after memReady.
REQ-019 memReq sampled high in IDLE the cycle after DONE is accepted normally (back-to-back throughput = LATENCY+2 cycles).
REQ-020 Block read: memReadData loaded with block [9:4] at the BUSY->DONE edge and held until the next read completes.
REQ-021 Block write: whole 128-bit latched data stored at block [9:4]; memReadData unchanged.
REQ-022 Word write: latched [31:0] stored into word [3:2] of block [9:4]; other three words unchanged.
REQ-023 Input changes after acceptance have no effect on the in-flight operation.
REQ-024 Read after write to the same block returns the written data.

Reset
REQ-025 reset=1 forces IDLE, counter 0, memReady 0, memBusy 0, memReadData 0, in the same edge, with priority over all other events.
REQ-026 Reset mid-operation aborts it: no array write, no memReady pulse.
REQ-027 Reset initialises the array so 32-bit word w (w = byte address >> 2, 0..255) holds value w zero-extended.

Structure
REQ-028 Shared package holds state encoding, BLOCK_BITS=128, WORD_BITS=32, ADDR_BITS=10 and field position constants for index/offset.
REQ-029 Storage is one sub-module, mem_block_array: synchronous write port with per-word enable, combinational block read, reset-time pattern init.
REQ-030 FSM, counter and request latch live in main_memory_ctrl.

Verification
REQ-031 Reset, then read address 0x010 -> memReady in 5th cycle after acceptance; memReadData = {32'h4,32'h5,32'h6,32'h7}.
REQ-032 Block write 0x3F0 with 128'hA..., then read 0x3F0 -> returned data equals written block exactly.
REQ-033 Word write 0x028 data 32'hDEADBEEF, then read 0x020 -> {32'h8,32'h9,32'hDEADBEEF,32'hB}.
REQ-034 memReq held high continuously with alternating addresses -> memReady exactly every LATENCY+2 cycles; mid-BUSY changes ignored.
REQ-035 Block write accepted, reset at 2nd BUSY cycle -> no memReady; later read of that block returns init pattern.
REQ-036 Repeat REQ-031 with LATENCY=1 and LATENCY=15 -> memReady 2 and 16 cycles after acceptance respectively.
